fifo_read_ctrl: RTL and testbench

FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

---
 rtl/fifo_read_ctrl_pkg.sv | 23 ++
 rtl/fifo_read_ctrl_chk.sv | 20 ++
 rtl/fifo_skid_buf.sv | 99 +++++++++
 rtl/fifo_read_ctrl.sv | 76 +++++++
 tb/tb_fifo_read_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_read_ctrl_pkg.sv
// Shared definitions for the FIFO read controller: default widths,
// buffer occupancy encoding and the read-enable headroom helper.
package fifo_read_ctrl_pkg;

  localparam int unsigned DATA_WIDTH_DEF  = 8;
  localparam int unsigned COUNT_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // True when the words held plus the word in flight, less the word leaving
  // this cycle, leave room for one more word in the 2-entry buffer.
  // A pop always implies occupancy >= 1, so the subtraction cannot underflow.
  function automatic logic has_room(input occ_e occ, input logic in_flight, input logic pop);
    logic [1:0] w_sum;
    w_sum = 2'(occ) + {1'b0, in_flight} - {1'b0, pop};
    return (w_sum < 2'd2);
  endfunction

endpackage

// File: rtl/fifo_read_ctrl_chk.sv
// Invariant checker for the read controller: no capture into a full
// buffer and no FIFO pop request while the FIFO reports empty.
module fifo_read_ctrl_chk
  import fifo_read_ctrl_pkg::*;
(
  input logic rclk,
  input logic rrst,
  input logic capture,
  input occ_e occ,
  input logic fifo_ren,
  input logic fifo_empty
);

  a_no_overflow: assert property (@(posedge rclk) disable iff (!rrst)
    !(capture && (occ == OCC_TWO)));

  a_no_ren_empty: assert property (@(posedge rclk)
    !(fifo_ren && fifo_empty));

endmodule

// File: rtl/fifo_skid_buf.sv
// Two-entry FIFO-ordered buffer. The head entry is presented on o_head;
// a push and a pop in the same cycle shift tail to head and refill.
module fifo_skid_buf
  import fifo_read_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [DATA_WIDTH-1:0] i_din,
  output logic [DATA_WIDTH-1:0] o_head,
  output occ_e                  o_occ
);

  occ_e                  r_occ;
  occ_e                  w_occ_nxt;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [DATA_WIDTH-1:0] w_head_nxt;
  logic [DATA_WIDTH-1:0] w_tail_nxt;

  // Next occupancy and entry contents for every push/pop combination.
  always_comb begin
    w_occ_nxt  = r_occ;
    w_head_nxt = r_head;
    w_tail_nxt = r_tail;
    case ({i_push, i_pop})
      2'b10: begin
        case (r_occ)
          OCC_EMPTY: begin
            w_head_nxt = i_din;
            w_occ_nxt  = OCC_ONE;
          end
          OCC_ONE: begin
            w_tail_nxt = i_din;
            w_occ_nxt  = OCC_TWO;
          end
          default: begin
            w_occ_nxt = r_occ;
          end
        endcase
      end
      2'b01: begin
        case (r_occ)
          OCC_ONE: begin
            w_occ_nxt = OCC_EMPTY;
          end
          OCC_TWO: begin
            w_head_nxt = r_tail;
            w_occ_nxt  = OCC_ONE;
          end
          default: begin
            w_occ_nxt = r_occ;
          end
        endcase
      end
      2'b11: begin
        case (r_occ)
          OCC_EMPTY: begin
            w_head_nxt = i_din;
            w_occ_nxt  = OCC_ONE;
          end
          OCC_ONE: begin
            w_head_nxt = i_din;
          end
          OCC_TWO: begin
            w_head_nxt = r_tail;
            w_tail_nxt = i_din;
          end
          default: begin
            w_occ_nxt = r_occ;
          end
        endcase
      end
      default: begin
        w_occ_nxt = r_occ;
      end
    endcase
  end

  // Buffer state register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_occ  <= OCC_EMPTY;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_occ  <= w_occ_nxt;
      r_head <= w_head_nxt;
      r_tail <= w_tail_nxt;
    end
  end

  assign o_head = r_head;
  assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side controller for the async FIFO: pops words into a 2-entry
// buffer and presents them as a valid/ready stream, counting deliveries.
module fifo_read_ctrl
  import fifo_read_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
  input  logic                   rclk,
  input  logic                   rrst,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_rdata,
  output logic                   fifo_ren,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic [COUNT_WIDTH-1:0] rd_count,
  output logic                   busy
);

  logic                   r_in_flight;
  logic [COUNT_WIDTH-1:0] r_count;
  occ_e                   w_occ;
  logic [DATA_WIDTH-1:0]  w_head;
  logic                   w_pop;
  logic                   w_ren;
  logic                   w_valid;

  // Stream handshake and FIFO pop request; everything is held off during reset.
  always_comb begin
    w_valid = rrst & (w_occ != OCC_EMPTY);
    w_pop   = w_valid & m_ready;
    w_ren   = rrst & !fifo_empty & has_room(w_occ, r_in_flight, w_pop);
  end

  // In-flight flag tracks the one-cycle FIFO read latency; counter tracks pops.
  always_ff @(posedge rclk) begin
    if (!rrst) begin
      r_in_flight <= 1'b0;
      r_count     <= '0;
    end else begin
      r_in_flight <= w_ren;
      if (w_pop) begin
        r_count <= r_count + COUNT_WIDTH'(1);
      end
    end
  end

  fifo_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .i_clk   (rclk),
    .i_rst_n (rrst),
    .i_push  (r_in_flight),
    .i_pop   (w_pop),
    .i_din   (fifo_rdata),
    .o_head  (w_head),
    .o_occ   (w_occ)
  );

  fifo_read_ctrl_chk u_chk (
    .rclk       (rclk),
    .rrst       (rrst),
    .capture    (r_in_flight),
    .occ        (w_occ),
    .fifo_ren   (w_ren),
    .fifo_empty (fifo_empty)
  );

  assign fifo_ren = w_ren;
  assign m_valid  = w_valid;
  assign m_data   = w_head;
  assign rd_count = rrst ? r_count : '0;
  assign busy     = rrst & ((w_occ != OCC_EMPTY) | r_in_flight);

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Testbench for fifo_read_ctrl: cycle vector table for reset and the
// single-word path, then a FIFO model with a scoreboard for streaming,
// backpressure, random empty/ready traffic and mid-operation reset.
module tb_fifo_read_ctrl;

  logic        rclk;
  logic        rrst;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata;
  logic        fifo_ren;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic [15:0] rd_count;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_read_ctrl #(
    .DATA_WIDTH  (8),
    .COUNT_WIDTH (16)
  ) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_ren   (fifo_ren),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .rd_count   (rd_count),
    .busy       (busy)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  typedef struct {
    logic        rst;
    logic        empty;
    logic        ready;
    logic [7:0]  rdata;
    logic        exp_ren;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic        exp_busy;
    logic [15:0] exp_count;
  } vec_t;

  vec_t tbl[13];

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  bit         stall_prev;
  logic [7:0] stall_data;
  int         ren_cnt;
  logic       last_busy;
  int         cyc;
  int         v_first;
  int         v_last;
  int         v_cnt;

  function automatic vec_t mk(input logic rst, input logic empty, input logic ready,
                              input logic [7:0] rdata, input logic e_ren, input logic e_valid,
                              input logic [7:0] e_data, input logic e_busy, input logic [15:0] e_cnt);
    vec_t v;
    v.rst = rst; v.empty = empty; v.ready = ready; v.rdata = rdata;
    v.exp_ren = e_ren; v.exp_valid = e_valid; v.exp_data = e_data;
    v.exp_busy = e_busy; v.exp_count = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle with the FIFO model: drive, sample at +1, then update
  // the FIFO read data one cycle after an accepted pop.
  task automatic step(input logic rst, input logic rdy, input logic force_empty);
    bit did;
    logic [7:0] w;
    rrst       = rst;
    m_ready    = rdy;
    fifo_empty = force_empty | (fq.size() == 0);
    #1;
    if (fifo_empty) chk("ren_while_empty", 32'(fifo_ren), 32'd0);
    if (rst && stall_prev) begin
      chk("hold_valid", 32'(m_valid), 32'd1);
      chk("hold_data", 32'(m_data), 32'(stall_data));
    end
    if (m_valid) begin
      if (v_first < 0) v_first = cyc;
      v_last = cyc;
      v_cnt++;
    end
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_word: got 0x%0h, expected no word", m_data);
      end else begin
        chk("order", 32'(m_data), 32'(exp_q.pop_front()));
      end
    end
    stall_prev = rst && m_valid && !m_ready;
    stall_data = m_data;
    last_busy  = busy;
    did        = fifo_ren && !fifo_empty;
    if (did) ren_cnt++;
    @(posedge rclk);
    #1;
    cyc++;
    if (did) begin
      w = fq.pop_front();
      exp_q.push_back(w);
      fifo_rdata = w;
    end else begin
      fifo_rdata = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    fq.delete();
    exp_q.delete();
    stall_prev = 1'b0;
    ren_cnt = 0;
    v_first = -1;
    v_last  = -1;
    v_cnt   = 0;
  endtask

  task automatic drain(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (fq.size() == 0 && exp_q.size() == 0 && !last_busy) break;
    end
    chk("drain_in_budget", 32'(i < budget), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int total;
    rrst = 1'b0; fifo_empty = 1'b1; m_ready = 1'b0; fifo_rdata = 8'h00;
    stall_prev = 1'b0; cyc = 0; ren_cnt = 0; v_first = -1; v_last = -1; v_cnt = 0;

    //           rst   empty ready rdata   ren   valid data   busy  count
    tbl[0]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0);
    tbl[1]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0);
    tbl[3]  = mk(1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0);
    tbl[4]  = mk(1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b1, 16'd0);
    tbl[5]  = mk(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 16'd0);
    tbl[6]  = mk(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 16'd1);
    tbl[7]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 16'd1);
    tbl[8]  = mk(1'b1, 1'b1, 1'b0, 8'hB7, 1'b0, 1'b0, 8'h00, 1'b1, 16'd1);
    tbl[9]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hB7, 1'b1, 16'd1);
    tbl[10] = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hB7, 1'b1, 16'd1);
    tbl[11] = mk(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'hB7, 1'b1, 16'd1);
    tbl[12] = mk(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 16'd2);

    @(posedge rclk);
    #1;
    for (int i = 0; i < 13; i++) begin
      rrst = tbl[i].rst; fifo_empty = tbl[i].empty;
      m_ready = tbl[i].ready; fifo_rdata = tbl[i].rdata;
      #1;
      chk($sformatf("vec%0d_ren", i), 32'(fifo_ren), 32'(tbl[i].exp_ren));
      chk($sformatf("vec%0d_valid", i), 32'(m_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
      chk($sformatf("vec%0d_count", i), 32'(rd_count), 32'(tbl[i].exp_count));
      if (tbl[i].exp_valid) chk($sformatf("vec%0d_data", i), 32'(m_data), 32'(tbl[i].exp_data));
      @(posedge rclk);
      #1;
    end

    // Streaming 32 words at full rate.
    do_reset();
    for (int i = 0; i < 32; i++) fq.push_back(8'(i));
    drain(100);
    chk("stream_count", 32'(rd_count), 32'd32);
    chk("stream_valid_cycles", 32'(v_cnt), 32'd32);
    chk("stream_contiguous", 32'(v_last - v_first + 1), 32'd32);

    // Backpressure: 4 words queued, consumer stalled for 10 cycles.
    do_reset();
    for (int i = 0; i < 4; i++) fq.push_back(8'h31 + 8'(i));
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    chk("bp_ren_count", 32'(ren_cnt), 32'd2);
    chk("bp_valid", 32'(m_valid), 32'd1);
    chk("bp_head", 32'(m_data), 32'h31);
    drain(50);
    chk("bp_count", 32'(rd_count), 32'd4);

    // Random empty flag and consumer readiness.
    do_reset();
    total = 0;
    for (int i = 0; i < 1000; i++) begin
      while (fq.size() < 4) begin
        fq.push_back(8'($urandom));
        total++;
      end
      step(1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end
    drain(200);
    chk("rand_count", 32'(rd_count), 32'(16'(total)));

    // Reset while the buffer is full and words remain in the FIFO.
    do_reset();
    for (int i = 0; i < 6; i++) fq.push_back(8'h51 + 8'(i));
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    chk("mr_pre_valid", 32'(m_valid), 32'd1);
    chk("mr_pre_busy", 32'(busy), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    fq.delete();
    exp_q.delete();
    stall_prev = 1'b0;
    for (int i = 0; i < 4; i++) fq.push_back(8'hC0 + 8'(i));
    rrst = 1'b1;
    #1;
    chk("mr_valid", 32'(m_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_count", 32'(rd_count), 32'd0);
    drain(50);
    chk("mr_resume_count", 32'(rd_count), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
